// File: rtl/immediate_decoder.sv
// RV32I immediate extraction for the decode stage: a combinational result for
// same-cycle consumers plus a registered copy for the next pipeline stage.
module immediate_decoder #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      type_,
    input  logic [XLEN-1:0] in,
    output logic [XLEN-1:0] out,
    output logic            illegal,
    output logic [XLEN-1:0] out_q,
    output logic            illegal_q
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            sgn;

    // in[31] is the sign for every format, so one replicated bit feeds all of them.
    assign sgn   = in[31];
    assign imm_i = {{20{sgn}}, in[31:20]};
    assign imm_s = {{20{sgn}}, in[31:25], in[11:7]};
    assign imm_b = {{19{sgn}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
    assign imm_u = {in[31:12], 12'h000};
    assign imm_j = {{11{sgn}}, in[31], in[19:12], in[20], in[30:21], 1'b0};

    // Ternary chain rather than a case so an unknown type_ yields X in simulation.
    assign out = (type_ == FMT_I) ? imm_i :
                 (type_ == FMT_S) ? imm_s :
                 (type_ == FMT_B) ? imm_b :
                 (type_ == FMT_U) ? imm_u :
                 (type_ == FMT_J) ? imm_j :
                                    '0;

    assign illegal = (type_ > FMT_J);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= out;
            illegal_q <= illegal;
        end
    end

endmodule

// File: tb/tb_immediate_decoder.sv
// Directed and randomized checks of immediate_decoder against an arithmetic
// model of the RV32I immediate formats.
module tb_immediate_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  type_;
    logic [31:0] in;
    logic [31:0] out;
    logic        illegal;
    logic [31:0] out_q;
    logic        illegal_q;

    int checks = 0;
    int errors = 0;

    immediate_decoder #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .type_     (type_),
        .in        (in),
        .out       (out),
        .illegal   (illegal),
        .out_q     (out_q),
        .illegal_q (illegal_q)
    );

    always #5 clk = ~clk;

    // Immediate value as a signed integer: unsigned field weights, minus the
    // sign bit's weight when in[31] is set. Returns {illegal, out}.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] w);
        int v;
        int s;
        s = w[31] ? 1 : 0;
        case (t)
            3'd0: v = int'(w[30:20]) - s * 2048;
            3'd1: v = int'(w[30:25]) * 32 + int'(w[11:7]) - s * 2048;
            3'd2: v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - s * 4096;
            3'd3: v = int'(w & 32'hfffff000);
            3'd4: v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - s * 1048576;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, 32'(v)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive away from the rising edge, check the combinational outputs, then
    // check the registered copy one edge later.
    task automatic apply(input string tag, input logic [2:0] t, input logic [31:0] w,
                         input logic [31:0] exp_out, input logic exp_ill);
        @(negedge clk);
        type_ = t;
        in    = w;
        #1;
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
        @(posedge clk);
        #1;
        chk({tag, "_out_q"}, out_q, exp_out);
        chk({tag, "_ill_q"}, {31'b0, illegal_q}, {31'b0, exp_ill});
    endtask

    initial begin
        logic [32:0] m;
        logic [2:0]  t;
        logic [31:0] w;

        reset = 1'b1;
        type_ = 3'd4;
        in    = 32'h00100000;
        #2;
        chk("rst_out_q", out_q, 32'h0);
        chk("rst_ill_q", {31'b0, illegal_q}, 32'h0);
        chk("rst_comb_out", out, 32'h00000800);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors.
        apply("i_neg",  3'd0, 32'hfff00000, 32'hffffffff, 1'b0);
        apply("i_pos",  3'd0, 32'h7ff00000, 32'h000007ff, 1'b0);
        apply("s_neg",  3'd1, 32'hfe000f80, 32'hffffffff, 1'b0);
        apply("b_neg",  3'd2, 32'hfe000f00, 32'hfffff7fe, 1'b0);
        apply("b_b11",  3'd2, 32'h00000080, 32'h00000800, 1'b0);
        apply("u_neg",  3'd3, 32'hfffff000, 32'hfffff000, 1'b0);
        apply("j_b11",  3'd4, 32'h00100000, 32'h00000800, 1'b0);
        apply("rsv5",   3'd5, 32'hffffffff, 32'h0, 1'b1);
        apply("rsv6",   3'd6, 32'hffffffff, 32'h0, 1'b1);
        apply("j_neg",  3'd4, 32'hffeff000, 32'hfffff7fe, 1'b0);
        apply("rsv7",   3'd7, 32'hffffffff, 32'h0, 1'b1);
        apply("j_neg2", 3'd4, 32'hffeff000, 32'hfffff7fe, 1'b0);

        // Asynchronous reset between edges while out_q is nonzero.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_out_q", out_q, 32'h0);
        chk("arst_ill_q", {31'b0, illegal_q}, 32'h0);
        chk("arst_comb_out", out, 32'hfffff7fe);
        type_ = 3'd3;
        in    = 32'h12345678;
        @(posedge clk);
        #1;
        chk("arst_hold_out_q", out_q, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_out_q", out_q, 32'h12345000);
        chk("rel_ill_q", {31'b0, illegal_q}, 32'h0);

        // Randomized vectors against the model.
        for (int i = 0; i < 300; i++) begin
            t = 3'($urandom_range(0, 7));
            w = $urandom;
            m = model(t, w);
            apply("rnd", t, w, m[31:0], m[32]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
